i2c_cmd_sequencer: RTL



---
 rtl/i2c_seq_pkg.sv | 32 +++
 rtl/i2c_seq_fifo.sv | 69 ++++++
 rtl/i2c_cmd_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_seq_pkg.sv
// -----------------------------------------------------------------------------
// i2c_seq_pkg
// Shared definitions for the I2C command sequencer:
//   - sequencer state encoding
//   - command FIFO entry layout {addr[6:0], rw, wdata[7:0]}
//   - data pushed as the response of a read that timed out
// Optional feature macro used by the sequencer: I2C_SEQ_TIMEOUT_EN
// -----------------------------------------------------------------------------
package i2c_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } seq_state_e;

    // Command entry: bits [15:9] address, bit [8] rw, bits [7:0] write data
    localparam int CMD_W         = 16;
    localparam int CMD_WDATA_LSB = 0;
    localparam int CMD_RW_BIT    = 8;
    localparam int CMD_ADDR_LSB  = 9;

    localparam logic [7:0] RSP_TIMEOUT_DATA = 8'hFF;

    function automatic logic [CMD_W-1:0] pack_cmd(input logic [6:0] addr,
                                                  input logic       rw,
                                                  input logic [7:0] wdata);
        return {addr, rw, wdata};
    endfunction

endpackage

// File: rtl/i2c_seq_fifo.sv
// -----------------------------------------------------------------------------
// i2c_seq_fifo
// Synchronous FIFO with occupancy count. Pointers carry one extra MSB so that
// a full FIFO (same index, different wrap bit) is distinguishable from empty.
// Push while full and pop while empty are ignored.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write strobe and data
//   pop                 advance the head
//   pop_data            head entry (valid while !empty)
//   empty               FIFO holds no entries
//   level               number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module i2c_seq_fifo
    import i2c_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign level   = wr_ptr_q - rd_ptr_q;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_cmd_sequencer
// Buffers host write/read commands and issues them one at a time to an I2C
// master (addr/data_in/rw/enable/ready). Read data returned by the master is
// captured into a response FIFO for the host.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              host command handshake
//   cmd_addr/cmd_rw/cmd_wdata        command fields (wdata ignored for reads)
//   rsp_valid/rsp_ready/rsp_rdata    host response handshake and data
//   m_addr/m_data_in/m_rw/m_enable   registered outputs to the master
//   m_data_out/m_ready               master read data and idle flag
//   busy                             sequencer active or commands pending
//   cmd_level                        command FIFO occupancy
//   timeout_err                      sticky watchdog flag (I2C_SEQ_TIMEOUT_EN)
// Optional feature macro: I2C_SEQ_TIMEOUT_EN
// -----------------------------------------------------------------------------
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int CMD_DEPTH      = 4,
    parameter int RSP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [6:0]                    cmd_addr,
    input  logic                          cmd_rw,
    input  logic [7:0]                    cmd_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [7:0]                    rsp_rdata,
    output logic [6:0]                    m_addr,
    output logic [7:0]                    m_data_in,
    output logic                          m_rw,
    output logic                          m_enable,
    input  logic [7:0]                    m_data_out,
    input  logic                          m_ready,
    output logic                          busy,
    output logic [$clog2(CMD_DEPTH):0]    cmd_level
`ifdef I2C_SEQ_TIMEOUT_EN
    ,
    output logic                          timeout_err
`endif
);

    localparam int CLW = $clog2(CMD_DEPTH) + 1;
    localparam int RLW = $clog2(RSP_DEPTH) + 1;

    seq_state_e       state_q, state_d;
    logic [6:0]       m_addr_q, m_addr_d;
    logic [7:0]       m_data_in_q, m_data_in_d;
    logic             m_rw_q, m_rw_d;
    logic             m_enable_q, m_enable_d;

    logic             cmd_push;
    logic             cmd_pop;
    logic             cmd_empty;
    logic             cmd_full;
    logic [CMD_W-1:0] cmd_head;
    logic [6:0]       head_addr;
    logic             head_rw;
    logic [7:0]       head_wdata;

    logic             rsp_push;
    logic [7:0]       rsp_push_data;
    logic             rsp_empty;
    logic             rsp_full;
    logic [RLW-1:0]   rsp_level;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic             tmo_hit;
`endif

    // Full flags come from registered pointers, so a pop on a full FIFO only
    // frees space on the following cycle
    assign cmd_full  = (cmd_level == CLW'(CMD_DEPTH));
    assign rsp_full  = (rsp_level == RLW'(RSP_DEPTH));
    assign cmd_ready = !cmd_full;
    assign cmd_push  = cmd_valid && cmd_ready;
    assign rsp_valid = !rsp_empty;

    assign head_addr  = cmd_head[CMD_ADDR_LSB +: 7];
    assign head_rw    = cmd_head[CMD_RW_BIT];
    assign head_wdata = cmd_head[CMD_WDATA_LSB +: 8];

    i2c_seq_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_push),
        .push_data (pack_cmd(cmd_addr, cmd_rw, cmd_wdata)),
        .pop       (cmd_pop),
        .pop_data  (cmd_head),
        .empty     (cmd_empty),
        .level     (cmd_level)
    );

    i2c_seq_fifo #(.WIDTH(8), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_push),
        .push_data (rsp_push_data),
        .pop       (rsp_valid && rsp_ready),
        .pop_data  (rsp_rdata),
        .empty     (rsp_empty),
        .level     (rsp_level)
    );

    // Next-state and master-output logic. Outputs to the master are loaded on
    // the IDLE->ISSUE transition so m_enable is high exactly while in S_ISSUE;
    // the command is popped during S_ISSUE. A read waits in S_IDLE while the
    // response FIFO is full, which guarantees its response always has a slot.
    always_comb begin
        state_d       = state_q;
        m_addr_d      = m_addr_q;
        m_data_in_d   = m_data_in_q;
        m_rw_d        = m_rw_q;
        m_enable_d    = 1'b0;
        cmd_pop       = 1'b0;
        rsp_push      = 1'b0;
        rsp_push_data = m_data_out;
`ifdef I2C_SEQ_TIMEOUT_EN
        timeout_err_d = timeout_err_q;
        tmo_hit       = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`endif
        case (state_q)
            S_IDLE: begin
                if (!cmd_empty && m_ready && !(head_rw && rsp_full)) begin
                    state_d     = S_ISSUE;
                    m_enable_d  = 1'b1;
                    m_addr_d    = head_addr;
                    m_data_in_d = head_wdata;
                    m_rw_d      = head_rw;
                end
            end
            S_ISSUE: begin
                cmd_pop = 1'b1;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!m_ready) begin
                    state_d = S_WAIT_DONE;
                end
`ifdef I2C_SEQ_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                    rsp_push      = m_rw_q;
                    rsp_push_data = RSP_TIMEOUT_DATA;
                end
`endif
            end
            S_WAIT_DONE: begin
                if (m_ready) begin
                    state_d  = S_IDLE;
                    rsp_push = m_rw_q;
                end
`ifdef I2C_SEQ_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                    rsp_push      = m_rw_q;
                    rsp_push_data = RSP_TIMEOUT_DATA;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
`ifdef I2C_SEQ_TIMEOUT_EN
        // Counts cycles spent in one wait state; any state change restarts it
        if ((state_d == state_q) &&
            ((state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE))) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end else begin
            tmo_cnt_d = '0;
        end
`endif
    end

    // Sequencer state and registered master outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            m_addr_q      <= '0;
            m_data_in_q   <= '0;
            m_rw_q        <= 1'b0;
            m_enable_q    <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            m_addr_q      <= m_addr_d;
            m_data_in_q   <= m_data_in_d;
            m_rw_q        <= m_rw_d;
            m_enable_q    <= m_enable_d;
`ifdef I2C_SEQ_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign m_addr    = m_addr_q;
    assign m_data_in = m_data_in_q;
    assign m_rw      = m_rw_q;
    assign m_enable  = m_enable_q;
    assign busy      = (state_q != S_IDLE) || !cmd_empty;
`ifdef I2C_SEQ_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`endif

endmodule
